// File: rtl/bsg_manycore_array_reset_sequencer.sv
// Bring-up sequencer for one compute-tile subarray.
// All columns are held in reset for hold_cycles_p cycles after an accepted
// start. Columns are then released one per stagger_cycles_p cycles, west to
// east. Each column also receives its global X/Y coordinate.
//
// Ports:
//   clk_i, reset_n_i     clock and async active-low reset
//   start_v_i            request a (re)sequence; accepted when start_ready_o=1
//   start_ready_o        high in IDLE and DONE
//   origin_x_i/_y_i      coordinates of column 0 / top row, sampled on accept
//   reset_o              per-column active-high reset
//   global_x_o/_y_o      packed per-column coordinates, column c at [c*W +: W]
//   done_o               every column has been released
//
// Optional build macro BSG_MANYCORE_RESET_SEQ_STATUS_EN adds two outputs:
//   cols_released_o      number of columns whose reset_o is 0
//   done_pulse_o         high for one cycle on entry to DONE
module bsg_manycore_array_reset_sequencer #(
    parameter int unsigned num_cols_p       = 4,
    parameter int unsigned x_cord_width_p   = 7,
    parameter int unsigned y_cord_width_p   = 7,
    parameter int unsigned hold_cycles_p    = 16,
    parameter int unsigned stagger_cycles_p = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 start_v_i,
    output logic                                 start_ready_o,
    input  logic [x_cord_width_p-1:0]            origin_x_i,
    input  logic [y_cord_width_p-1:0]            origin_y_i,
    output logic [num_cols_p-1:0]                reset_o,
    output logic [num_cols_p*x_cord_width_p-1:0] global_x_o,
    output logic [num_cols_p*y_cord_width_p-1:0] global_y_o,
    output logic                                 done_o
`ifdef BSG_MANYCORE_RESET_SEQ_STATUS_EN
    ,
    output logic [$clog2(num_cols_p+1)-1:0]      cols_released_o,
    output logic                                 done_pulse_o
`endif
);

    localparam int unsigned MAX_CYC = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p
                                                                         : stagger_cycles_p;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned COL_W   = $clog2(num_cols_p + 1);
    localparam int unsigned XW      = x_cord_width_p;
    localparam int unsigned YW      = y_cord_width_p;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [COL_W-1:0]             col_q, col_d;
    logic [num_cols_p-1:0]        reset_d;
    logic [num_cols_p*XW-1:0]     global_x_d;
    logic [num_cols_p*YW-1:0]     global_y_d;
    logic                         done_d;
    logic                         ready_d;

    // State, counters and all outputs are flops.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            col_q         <= '0;
            reset_o       <= '1;
            global_x_o    <= '0;
            global_y_o    <= '0;
            done_o        <= 1'b0;
            start_ready_o <= 1'b1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            reset_o       <= reset_d;
            global_x_o    <= global_x_d;
            global_y_o    <= global_y_d;
            done_o        <= done_d;
            start_ready_o <= ready_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        reset_d    = reset_o;
        global_x_d = global_x_o;
        global_y_d = global_y_o;
        done_d     = done_o;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_v_i) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    col_d   = '0;
                    reset_d = '1;
                    done_d  = 1'b0;
                    for (int unsigned c = 0; c < num_cols_p; c++) begin
                        global_x_d[c*XW +: XW] = XW'(origin_x_i + XW'(c));
                        global_y_d[c*YW +: YW] = origin_y_i;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == CNT_W'(hold_cycles_p - 1)) begin
                    cnt_d      = '0;
                    reset_d[0] = 1'b0;
                    col_d      = COL_W'(1);
                    if (num_cols_p == 1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(stagger_cycles_p - 1)) begin
                    cnt_d = '0;
                    for (int unsigned c = 0; c < num_cols_p; c++) begin
                        if (COL_W'(c) == col_q) begin
                            reset_d[c] = 1'b0;
                        end
                    end
                    col_d = col_q + COL_W'(1);
                    // The column just cleared was the easternmost one.
                    if (col_q == COL_W'(num_cols_p - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == DONE);
    end

`ifdef BSG_MANYCORE_RESET_SEQ_STATUS_EN
    logic done_pulse_q;

    // One-cycle flag marking the first cycle spent in DONE.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

    // The column index is the count of released columns: 0 on accept, N in DONE.
    assign cols_released_o = col_q;
    assign done_pulse_o    = done_pulse_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_array_reset_sequencer.sv
module tb_bsg_manycore_array_reset_sequencer;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int S  = 2;
    localparam int XW = 7;
    localparam int YW = 7;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              start_v_i;
    logic              start_ready_o;
    logic [XW-1:0]     origin_x_i;
    logic [YW-1:0]     origin_y_i;
    logic [N-1:0]      reset_o;
    logic [N*XW-1:0]   global_x_o;
    logic [N*YW-1:0]   global_y_o;
    logic              done_o;
`ifdef BSG_MANYCORE_RESET_SEQ_STATUS_EN
    logic [2:0]        cols_released_o;
    logic              done_pulse_o;
`endif

    bsg_manycore_array_reset_sequencer #(
        .num_cols_p      (N),
        .x_cord_width_p  (XW),
        .y_cord_width_p  (YW),
        .hold_cycles_p   (H),
        .stagger_cycles_p(S)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .start_v_i      (start_v_i),
        .start_ready_o  (start_ready_o),
        .origin_x_i     (origin_x_i),
        .origin_y_i     (origin_y_i),
        .reset_o        (reset_o),
        .global_x_o     (global_x_o),
        .global_y_o     (global_y_o),
        .done_o         (done_o)
`ifdef BSG_MANYCORE_RESET_SEQ_STATUS_EN
        ,
        .cols_released_o(cols_released_o),
        .done_pulse_o   (done_pulse_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: only "is a sequence active", cycles since accept, latched origins.
    bit           m_have = 1'b0;
    int           m_k    = 0;
    logic [XW-1:0] m_ox  = '0;
    logic [YW-1:0] m_oy  = '0;

    function automatic int m_rel();
        int r;
        if (!m_have || m_k < H) return 0;
        r = (m_k - H) / S + 1;
        return (r > N) ? N : r;
    endfunction

    function automatic bit m_ready();
        return !m_have || (m_rel() == N);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        int            rel;
        logic [N-1:0]  er;
        logic [N*XW-1:0] egx;
        logic [N*YW-1:0] egy;
        rel = m_rel();
        for (int c = 0; c < N; c++) begin
            er[c]            = (c >= rel);
            egx[c*XW +: XW]  = m_have ? XW'(m_ox + XW'(c)) : '0;
            egy[c*YW +: YW]  = m_have ? m_oy : '0;
        end
        check({tag, ".reset_o"}, 64'(reset_o), 64'(er));
        check({tag, ".done_o"}, 64'(done_o), 64'(m_have && rel == N));
        check({tag, ".ready"}, 64'(start_ready_o), 64'(m_ready()));
        check({tag, ".global_x"}, 64'(global_x_o), 64'(egx));
        check({tag, ".global_y"}, 64'(global_y_o), 64'(egy));
`ifdef BSG_MANYCORE_RESET_SEQ_STATUS_EN
        check({tag, ".cols_released"}, 64'(cols_released_o), 64'(rel));
        check({tag, ".done_pulse"}, 64'(done_pulse_o), 64'(m_have && m_k == H + (N-1)*S));
`endif
    endtask

    // One clock: drive at negedge, advance model at posedge, compare just after.
    task automatic step(input logic sv, input logic [XW-1:0] ox, input logic [YW-1:0] oy);
        bit acc;
        @(negedge clk_i);
        start_v_i  = sv;
        origin_x_i = ox;
        origin_y_i = oy;
        acc = sv && m_ready();
        @(posedge clk_i);
        if (acc) begin
            m_have = 1'b1;
            m_k    = 0;
            m_ox   = ox;
            m_oy   = oy;
        end else if (m_have && m_k < 1000) begin
            m_k++;
        end
        #1;
        compare_all("step");
    endtask

    // Asynchronous reset pulse between clock edges (called just after a step).
    task automatic async_reset();
        #2;
        start_v_i = 1'b0;
        reset_n_i = 1'b0;
        m_have    = 1'b0;
        #1;
        compare_all("async");
        check("async.reset_all", 64'(reset_o), 64'hF);
        @(negedge clk_i);
        reset_n_i = 1'b1;
    endtask

    typedef struct {
        logic [XW-1:0]   ox;
        logic [YW-1:0]   oy;
        logic [N*XW-1:0] gx;
        logic [N*YW-1:0] gy;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{ox: 7'd5,   oy: 7'd3,   gx: {7'd8, 7'd7, 7'd6, 7'd5},       gy: {4{7'd3}}};
        vecs[1] = '{ox: 7'd126, oy: 7'd9,   gx: {7'd1, 7'd0, 7'd127, 7'd126},   gy: {4{7'd9}}};
        vecs[2] = '{ox: 7'd0,   oy: 7'd127, gx: {7'd3, 7'd2, 7'd1, 7'd0},       gy: {4{7'd127}}};
        vecs[3] = '{ox: 7'd124, oy: 7'd64,  gx: {7'd127, 7'd126, 7'd125, 7'd124}, gy: {4{7'd64}}};

        reset_n_i  = 1'b0;
        start_v_i  = 1'b0;
        origin_x_i = '0;
        origin_y_i = '0;
        #12;
        compare_all("in_reset");
        check("in_reset.reset_o", 64'(reset_o), 64'hF);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step(1'b0, 7'd0, 7'd0);
        step(1'b0, 7'd0, 7'd0);
        check("idle.reset_o", 64'(reset_o), 64'hF);
        check("idle.ready", 64'(start_ready_o), 64'h1);

        // Table-driven sequences with explicit coordinate and release timing.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].ox, vecs[i].oy);
            check("vec.accept_reset", 64'(reset_o), 64'hF);
            for (int k = 1; k <= 11; k++) begin
                step(1'b0, XW'($urandom), YW'($urandom));
                if (k == 4) check("vec.col0_release", 64'(reset_o), 64'hE);
                if (k == 9) check("vec.not_done_yet", 64'(done_o), 64'h0);
                if (k == 10) begin
                    check("vec.done", 64'(done_o), 64'h1);
                    check("vec.all_released", 64'(reset_o), 64'h0);
                end
            end
            check("vec.gx", 64'(global_x_o), 64'(vecs[i].gx));
            check("vec.gy", 64'(global_y_o), 64'(vecs[i].gy));
        end

        // start held high: ignored until DONE, then re-accepted with new origins.
        step(1'b1, 7'd5, 7'd3);
        for (int k = 1; k <= 10; k++) step(1'b1, 7'd20, 7'd40);
        check("held.done", 64'(done_o), 64'h1);
        check("held.gx_kept", 64'(global_x_o), 64'({7'd8, 7'd7, 7'd6, 7'd5}));
        step(1'b1, 7'd20, 7'd40);
        check("held.reaccept_reset", 64'(reset_o), 64'hF);
        check("held.reaccept_gx", 64'(global_x_o), 64'({7'd23, 7'd22, 7'd21, 7'd20}));
        for (int k = 1; k <= 10; k++) step(1'b0, 7'd0, 7'd0);
        check("held.done2", 64'(done_o), 64'h1);

        // Async reset mid-RELEASE (after edge E0+7).
        step(1'b1, 7'd5, 7'd3);
        for (int k = 1; k <= 7; k++) step(1'b0, 7'd0, 7'd0);
        check("mid.partial", 64'(reset_o), 64'hC);
        async_reset();
        check("mid.done_low", 64'(done_o), 64'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 7'd1, 7'd1);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else step($urandom_range(0, 7) == 0, XW'($urandom), YW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
